// File: rtl/ks_pkg.sv
// Shared definitions for the Karplus-Strong pluck filter slice.
// Contents: the default sample, delay and decay widths, the LFSR tap mask
// and default seed, the filter state encoding and the LFSR step function.
package ks_pkg;

  localparam int SAMPLE_W = 24;
  localparam int DELAY_W  = 10;
  localparam int DECAY_W  = 8;
  localparam int LFSR_W   = 24;

  // Right-shifting Galois form of x^24+x^23+x^22+x^17+1
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 24'hE10000;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 24'hACE1F0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXCITE = 2'd1,
    RING   = 2'd2
  } state_t;

  // One Galois step. A nonzero state never maps to zero.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    logic [LFSR_W-1:0] nxt;
    nxt = {1'b0, v[LFSR_W-1:1]};
    if (v[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ks_pluck_filter_if.sv
// Sample-rate bus between the delay line/control logic and the pluck filter.
// Signals: pluck, delay, decay, atten and in flow into the filter; out and
// busy flow back. The drum input exists only when KS_DRUM_EN is defined.
// Modports: master (stimulus/control side), slave (the filter).
interface ks_pluck_filter_if
  #(parameter int SAMPLE_W = ks_pkg::SAMPLE_W,
    parameter int DELAY_W  = ks_pkg::DELAY_W,
    parameter int DECAY_W  = ks_pkg::DECAY_W);

  logic                       pluck;
  logic        [DELAY_W-1:0]  delay;
  logic        [DECAY_W-1:0]  decay;
  logic        [2:0]          atten;
  logic signed [SAMPLE_W-1:0] in;
  logic signed [SAMPLE_W-1:0] out;
  logic                       busy;
`ifdef KS_DRUM_EN
  logic                       drum;
`endif

  modport master (
    output pluck, delay, decay, atten, in,
`ifdef KS_DRUM_EN
    output drum,
`endif
    input  out, busy
  );

  modport slave (
    input  pluck, delay, decay, atten, in,
`ifdef KS_DRUM_EN
    input  drum,
`endif
    output out, busy
  );

endinterface

// File: rtl/ks_lfsr.sv
// Free-running 24-bit Galois noise LFSR for the pluck burst.
// Ports: clk (advance edge), rst_n (async active-low, loads SEED),
// en (advance when high), value (current LFSR state).
module ks_lfsr
  import ks_pkg::*;
  #(parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF)
  (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [LFSR_W-1:0] value
  );

  // LFSR state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (en) begin
      value <= lfsr_step(value);
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/ks_pluck_filter.sv
// Karplus-Strong feedback stage: takes the delay-line output sample and
// produces the next sample written back. A pluck injects one period of
// LFSR noise, after which a two-tap average scaled by decay/256 rings out.
// Ports: lrck (sample clock), rst_n (async active-low reset),
// bus (ks_pluck_filter_if.slave: pluck, delay, decay, atten, in -> out, busy).
// Optional build macro KS_DRUM_EN adds bus.drum: in RING with drum high the
// output is negated (saturating) whenever LFSR bit 0 is set.
module ks_pluck_filter
  import ks_pkg::*;
  #(parameter int                SAMPLE_W  = ks_pkg::SAMPLE_W,
    parameter int                DELAY_W   = ks_pkg::DELAY_W,
    parameter int                DECAY_W   = ks_pkg::DECAY_W,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 24'hACE1F0)
  (
    input logic                lrck,
    input logic                rst_n,
    ks_pluck_filter_if.slave   bus
  );

  localparam int PROD_W = SAMPLE_W + DECAY_W + 2;
  localparam logic [DELAY_W-1:0] CNT_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};
  localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

  state_t                     state_r;
  logic        [DELAY_W-1:0]  cnt_r;
  logic signed [SAMPLE_W-1:0] prev_in_r;
  logic signed [SAMPLE_W-1:0] out_r;
  logic                       pluck_q_r;

  logic        [LFSR_W-1:0]   lfsr_s;
  logic                       pluck_edge_s;
  logic        [DELAY_W-1:0]  load_s;
  logic signed [SAMPLE_W-1:0] noise_s;
  logic signed [SAMPLE_W:0]   sum_s;
  logic signed [SAMPLE_W:0]   avg_s;
  logic signed [PROD_W-1:0]   prod_s;
  logic signed [SAMPLE_W-1:0] ring_s;
  logic signed [SAMPLE_W-1:0] ring_fb_s;
  logic                       unused_prod_s;

  ks_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (lrck),
    .rst_n (rst_n),
    .en    (1'b1),
    .value (lfsr_s)
  );

  assign pluck_edge_s = bus.pluck & ~pluck_q_r;
  // A zero period still produces one burst sample
  assign load_s  = (bus.delay == {DELAY_W{1'b0}}) ? CNT_ONE : bus.delay;
  assign noise_s = SAMPLE_W'($signed(lfsr_s)) >>> bus.atten;

  // Two-tap average with floor, then gain; bits [SAMPLE_W+7:8] are prod >>> 8.
  // |avg| < 2^23 and decay < 256 keep the result inside SAMPLE_W bits.
  assign sum_s  = $signed({bus.in[SAMPLE_W-1], bus.in})
                + $signed({prev_in_r[SAMPLE_W-1], prev_in_r});
  assign avg_s  = sum_s >>> 1'd1;
  assign prod_s = PROD_W'(avg_s) * PROD_W'($signed({1'b0, bus.decay}));
  assign ring_s = prod_s[SAMPLE_W+7:8];
  assign unused_prod_s = ^{prod_s[PROD_W-1:SAMPLE_W+8], prod_s[7:0]};

`ifdef KS_DRUM_EN
  // Drum variant: random sign flip, saturating the one unnegatable value
  always_comb begin
    ring_fb_s = ring_s;
    if (bus.drum && lfsr_s[0]) begin
      if (ring_s == S_MIN) begin
        ring_fb_s = S_MAX;
      end else begin
        ring_fb_s = -ring_s;
      end
    end else begin
      ring_fb_s = ring_s;
    end
  end
`else
  assign ring_fb_s = ring_s;
`endif

  // Filter FSM, burst counter, input history and registered output
  always_ff @(posedge lrck or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {DELAY_W{1'b0}};
      prev_in_r <= {SAMPLE_W{1'b0}};
      out_r     <= {SAMPLE_W{1'b0}};
      pluck_q_r <= 1'b0;
    end else begin
      pluck_q_r <= bus.pluck;
      prev_in_r <= bus.in;
      case (state_r)
        IDLE: begin
          out_r <= {SAMPLE_W{1'b0}};
          if (pluck_edge_s) begin
            state_r <= EXCITE;
            cnt_r   <= load_s;
          end else begin
            state_r <= IDLE;
            cnt_r   <= cnt_r;
          end
        end
        EXCITE: begin
          out_r <= noise_s;
          if (pluck_edge_s) begin
            state_r <= EXCITE;
            cnt_r   <= load_s;
          end else if (cnt_r == CNT_ONE) begin
            state_r <= RING;
            cnt_r   <= cnt_r - CNT_ONE;
          end else begin
            state_r <= EXCITE;
            cnt_r   <= cnt_r - CNT_ONE;
          end
        end
        RING: begin
          out_r <= ring_fb_s;
          if (pluck_edge_s) begin
            state_r <= EXCITE;
            cnt_r   <= load_s;
          end else begin
            state_r <= RING;
            cnt_r   <= cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {DELAY_W{1'b0}};
          out_r   <= {SAMPLE_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.out  = out_r;
  assign bus.busy = (state_r == EXCITE);

endmodule

// File: tb/tb_ks_pluck_filter.sv
module tb_ks_pluck_filter;

  logic lrck  = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  ks_pluck_filter_if bus ();

  ks_pluck_filter dut (
    .lrck  (lrck),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 lrck = ~lrck;

  // Reference noise generator: x^24+x^23+x^22+x^17+1, seed ACE1F0
  function automatic logic [23:0] ref_step(input logic [23:0] v);
    logic [23:0] n;
    n = v >> 1;
    if (v[0] == 1'b1) n = n ^ 24'hE10000;
    return n;
  endfunction

  logic [23:0] m_lfsr;
  always @(posedge lrck or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 24'hACE1F0;
    else        m_lfsr <= ref_step(m_lfsr);
  end

  logic signed [23:0] exp_q[$];

  task automatic cyc();
    @(posedge lrck);
    #1;
  endtask

  task automatic test_reset();
    bus.pluck = 1'b0; bus.delay = 10'd4; bus.decay = 8'd255;
    bus.atten = 3'd0; bus.in = 24'sd0;
`ifdef KS_DRUM_EN
    bus.drum = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) cyc();
    checks++;
    if (bus.out !== 24'sd0) begin failures++; $display("FAIL reset_out got=%0d want=0", bus.out); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    #2 rst_n = 1'b1;
    repeat (3) cyc();
    checks++;
    if (bus.out !== 24'sd0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset out=%0d busy=%b want 0/0", bus.out, bus.busy);
    end
  endtask

  task automatic test_pluck();
    int busy_cnt;
    logic signed [23:0] e;
    bus.delay = 10'd4; bus.atten = 3'd0; bus.pluck = 1'b1;
    cyc();
    checks++;
    if (bus.busy !== 1'b1 || bus.out !== 24'sd0) begin
      failures++; $display("FAIL pluck_enter busy=%b out=%0d want 1/0", bus.busy, bus.out);
    end
    busy_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back($signed(m_lfsr) >>> bus.atten);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (bus.out !== e) begin failures++; $display("FAIL burst%0d got=%0d want=%0d", i, bus.out, e); end
      if (bus.busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 4 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL burst_len busy_cycles=%0d busy=%b want 4/0", busy_cnt, bus.busy);
    end
  endtask

  task automatic test_ring_positive();
    logic signed [23:0] e;
    bus.in = 24'sd1000; bus.decay = 8'd255;
    cyc();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(24'sd996);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (bus.out !== e || bus.busy !== 1'b0) begin
        failures++; $display("FAIL ring_pos%0d got=%0d busy=%b want=%0d busy=0", i, bus.out, bus.busy, e);
      end
    end
  endtask

  task automatic test_ring_negative();
    logic signed [23:0] e;
    bus.in = -24'sd4; bus.decay = 8'd128;
    cyc();
    bus.in = -24'sd3;
    exp_q.push_back(-24'sd2);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (bus.out !== e) begin failures++; $display("FAIL ring_neg_floor got=%0d want=%0d", bus.out, e); end
    bus.in = 24'sd5;
    exp_q.push_back(24'sd0);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (bus.out !== e) begin failures++; $display("FAIL ring_mixed got=%0d want=%0d", bus.out, e); end
  endtask

  task automatic test_repluck();
    int busy_cnt;
    logic signed [23:0] e;
    bus.pluck = 1'b0;
    cyc();
    bus.delay = 10'd3; bus.atten = 3'd1; bus.pluck = 1'b1;
    cyc();
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL repluck_enter busy=%b want=1", bus.busy); end
    busy_cnt = 1;
    bus.delay = 10'd7;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back($signed(m_lfsr) >>> bus.atten);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (bus.out !== e) begin failures++; $display("FAIL reburst%0d got=%0d want=%0d", i, bus.out, e); end
      if (bus.busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 3) begin failures++; $display("FAIL repluck_len busy_cycles=%0d want=3", busy_cnt); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL held_pluck%0d busy=%b want=0", i, bus.busy); end
    end
  endtask

  task automatic test_delay_zero();
    logic signed [23:0] e;
    bus.pluck = 1'b0;
    cyc();
    bus.delay = 10'd0; bus.atten = 3'd2; bus.pluck = 1'b1;
    cyc();
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL d0_enter busy=%b want=1", bus.busy); end
    exp_q.push_back($signed(m_lfsr) >>> bus.atten);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (bus.out !== e || bus.busy !== 1'b0) begin
      failures++; $display("FAIL d0_burst got=%0d busy=%b want=%0d busy=0", bus.out, bus.busy, e);
    end
  endtask

  task automatic test_async_reset();
    bus.pluck = 1'b0;
    cyc();
    bus.delay = 10'd8; bus.atten = 3'd0; bus.pluck = 1'b1;
    cyc();
    cyc();
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL pre_reset busy=%b want=1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out !== 24'sd0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL async_reset out=%0d busy=%b want 0/0", bus.out, bus.busy);
    end
    bus.pluck = 1'b0;
    @(posedge lrck);
    #3 rst_n = 1'b1;
    cyc();
    cyc();
    checks++;
    if (bus.out !== 24'sd0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL post_reset out=%0d busy=%b want 0/0", bus.out, bus.busy);
    end
  endtask

`ifdef KS_DRUM_EN
  task automatic test_drum();
    logic signed [23:0] e;
    bus.drum = 1'b1; bus.delay = 10'd1; bus.pluck = 1'b1;
    cyc();
    cyc();
    bus.in = 24'sd1000; bus.decay = 8'd255;
    cyc();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(m_lfsr[0] ? -24'sd996 : 24'sd996);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if (bus.out !== e) begin failures++; $display("FAIL drum%0d got=%0d want=%0d", i, bus.out, e); end
    end
    bus.drum = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pluck();
    test_ring_positive();
    test_ring_negative();
    test_repluck();
    test_delay_zero();
    test_async_reset();
`ifdef KS_DRUM_EN
    test_drum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
